wb_commit_unit: RTL and testbench

//  Writer side of the integer register file write port (RUWr/rd/RUDataWr).

---
 rtl/core_pkg.sv | 12 +
 rtl/wb_fifo.sv | 42 ++++
 rtl/wb_commit_unit.sv | 91 +++++++++
 tb/tb_wb_commit_unit.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared register-file write-port types and helpers for the commit unit.
package core_pkg;
    localparam int REG_AW = 5;
    localparam int XLEN_DEFAULT = 32;
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN_DEFAULT-1:0] data;
    } wb_entry_t;
    function automatic logic [31:0] rd_onehot(input logic [REG_AW-1:0] rd);
        return 32'd1 << rd;
    endfunction
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: DEPTH-entry FIFO holding long-latency unit results until the write port is free.
module wb_fifo
    import core_pkg::*;
#(
    parameter int W     = $bits(wb_entry_t),
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt;
    logic do_push, do_pop;
    assign full    = cnt == (AW+1)'(DEPTH);
    assign empty   = cnt == '0;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rp];
    // DEPTH is a power of two, so the pointers wrap naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            wp  <= do_push ? wp + 1'b1 : wp;
            rp  <= do_pop ? rp + 1'b1 : rp;
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end
endmodule

// File: rtl/wb_commit_unit.sv
// wb_commit_unit: merges WB-pipe and buffered LU results onto the register-file write port,
// tracks pending long-latency writes and raises the decode hazard stall. Option: WB_BYPASS_EN.
module wb_commit_unit
    import core_pkg::*;
#(
    parameter int XLEN       = XLEN_DEFAULT,
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pipe_valid,
    input  logic [4:0]        pipe_rd,
    input  logic [XLEN-1:0]   pipe_data,
    output logic              pipe_hold,
    input  logic              lu_valid,
    output logic              lu_ready,
    input  logic [4:0]        lu_rd,
    input  logic [XLEN-1:0]   lu_data,
    input  logic              iss_valid,
    input  logic [4:0]        iss_rd,
    output logic              iss_ready,
    input  logic [4:0]        dec_rs1,
    input  logic [4:0]        dec_rs2,
    input  logic [4:0]        dec_rd,
    output logic              hazard_stall,
`ifdef WB_BYPASS_EN
    output logic              fwd_rs1_hit,
    output logic              fwd_rs2_hit,
    output logic [XLEN-1:0]   fwd_data_rs1,
    output logic [XLEN-1:0]   fwd_data_rs2,
`endif
    output logic              ru_wr,
    output logic [4:0]        ru_rd,
    output logic [XLEN-1:0]   ru_data_wr
);
    localparam int EW = REG_AW + XLEN;
    localparam int CW = $clog2(STARVE_MAX + 1);
    logic pipe_win, pop, push, full, empty, pend_hit;
    logic [EW-1:0] head;
    logic [REG_AW-1:0] head_rd;
    logic [XLEN-1:0] head_data;
    logic [31:0] pending, pend_set, pend_clr;
    logic [CW-1:0] starve_cnt;
    wb_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (push),
        .pop  (pop),
        .din  ({lu_rd, lu_data}),
        .dout (head),
        .full (full),
        .empty(empty)
    );
    assign {head_rd, head_data} = head;
    // rd==0 results never reach the port: pipe ones lose arbitration, LU ones are dropped
    assign pipe_win  = pipe_valid & (pipe_rd != '0);
    assign pop       = ~pipe_win & ~empty;
    assign push      = lu_valid & ~full & (lu_rd != '0);
    assign lu_ready  = ~full;
    assign pipe_hold = starve_cnt >= CW'(STARVE_MAX);
    assign iss_ready = ~pending[iss_rd];
    assign pend_set  = (iss_valid & iss_ready & (iss_rd != '0)) ? rd_onehot(iss_rd) : '0;
    assign pend_clr  = pop ? rd_onehot(head_rd) : '0;
    assign pend_hit  = pending[dec_rs1] | pending[dec_rs2] | pending[dec_rd];
`ifdef WB_BYPASS_EN
    assign fwd_rs1_hit  = ru_wr & (ru_rd == dec_rs1) & (dec_rs1 != '0);
    assign fwd_rs2_hit  = ru_wr & (ru_rd == dec_rs2) & (dec_rs2 != '0);
    assign fwd_data_rs1 = ru_data_wr;
    assign fwd_data_rs2 = ru_data_wr;
    assign hazard_stall = pend_hit;
`else
    // without forwarding, a read of the register being written this cycle must wait
    assign hazard_stall = pend_hit | (ru_wr & (ru_rd != '0) & ((ru_rd == dec_rs1) | (ru_rd == dec_rs2)));
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending    <= '0;
            starve_cnt <= '0;
            ru_wr      <= 1'b0;
            ru_rd      <= '0;
            ru_data_wr <= '0;
        end else begin
            pending    <= ((pending & ~pend_clr) | pend_set) & ~32'd1;
            starve_cnt <= pop ? '0 : (!empty && !pipe_hold) ? starve_cnt + 1'b1 : starve_cnt;
            ru_wr      <= pipe_win | pop;
            ru_rd      <= pipe_win ? pipe_rd : pop ? head_rd : ru_rd;
            ru_data_wr <= pipe_win ? pipe_data : pop ? head_data : ru_data_wr;
        end
    end
endmodule

// File: tb/tb_wb_commit_unit.sv
// tb_wb_commit_unit: directed self-checking bench for wb_commit_unit.
module tb_wb_commit_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pipe_valid = 1'b0, lu_valid = 1'b0, iss_valid = 1'b0;
    logic [4:0] pipe_rd = '0, lu_rd = '0, iss_rd = '0, dec_rs1 = '0, dec_rs2 = '0, dec_rd = '0;
    logic [31:0] pipe_data = '0, lu_data = '0;
    logic pipe_hold, lu_ready, iss_ready, hazard_stall, ru_wr;
    logic [4:0] ru_rd;
    logic [31:0] ru_data_wr;
`ifdef WB_BYPASS_EN
    logic fwd_rs1_hit, fwd_rs2_hit;
    logic [31:0] fwd_data_rs1, fwd_data_rs2;
`endif
    int n_cmp = 0;
    int n_err = 0;

    wb_commit_unit dut (
        .clk(clk), .rst_n(rst_n),
        .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data), .pipe_hold(pipe_hold),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd), .hazard_stall(hazard_stall),
`ifdef WB_BYPASS_EN
        .fwd_rs1_hit(fwd_rs1_hit), .fwd_rs2_hit(fwd_rs2_hit),
        .fwd_data_rs1(fwd_data_rs1), .fwd_data_rs2(fwd_data_rs2),
`endif
        .ru_wr(ru_wr), .ru_rd(ru_rd), .ru_data_wr(ru_data_wr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_cmp++; if (ru_wr !== 1'b0) begin n_err++; $display("FAIL rst_ru_wr: got %b exp 0", ru_wr); end
        n_cmp++; if (ru_rd !== 5'd0) begin n_err++; $display("FAIL rst_ru_rd: got %0d exp 0", ru_rd); end
        n_cmp++; if (ru_data_wr !== 32'd0) begin n_err++; $display("FAIL rst_ru_data: got %h exp 0", ru_data_wr); end
        n_cmp++; if (lu_ready !== 1'b1) begin n_err++; $display("FAIL rst_lu_ready: got %b exp 1", lu_ready); end
        n_cmp++; if (pipe_hold !== 1'b0) begin n_err++; $display("FAIL rst_pipe_hold: got %b exp 0", pipe_hold); end
        n_cmp++; if (hazard_stall !== 1'b0) begin n_err++; $display("FAIL rst_hazard: got %b exp 0", hazard_stall); end
        rst_n = 1'b1;
    endtask

    task automatic test_pipe();
        pipe_valid = 1'b1; pipe_rd = 5'd5; pipe_data = 32'hA5;
        tick();
        pipe_valid = 1'b0;
        n_cmp++; if (ru_wr !== 1'b1) begin n_err++; $display("FAIL pipe_wr: got %b exp 1", ru_wr); end
        n_cmp++; if (ru_rd !== 5'd5) begin n_err++; $display("FAIL pipe_rd: got %0d exp 5", ru_rd); end
        n_cmp++; if (ru_data_wr !== 32'hA5) begin n_err++; $display("FAIL pipe_data: got %h exp a5", ru_data_wr); end
        dec_rs1 = 5'd5;
        #1;
`ifdef WB_BYPASS_EN
        n_cmp++; if (fwd_rs1_hit !== 1'b1) begin n_err++; $display("FAIL pipe_fwd_hit: got %b exp 1", fwd_rs1_hit); end
`else
        n_cmp++; if (hazard_stall !== 1'b1) begin n_err++; $display("FAIL pipe_raw_stall: got %b exp 1", hazard_stall); end
`endif
        dec_rs1 = 5'd0;
        tick();
        n_cmp++; if (ru_wr !== 1'b0) begin n_err++; $display("FAIL idle_wr: got %b exp 0", ru_wr); end
        n_cmp++; if (ru_rd !== 5'd5 || ru_data_wr !== 32'hA5) begin n_err++; $display("FAIL idle_hold: got %0d/%h exp 5/a5", ru_rd, ru_data_wr); end
    endtask

    task automatic test_lu();
        iss_valid = 1'b1; iss_rd = 5'd7;
        n_cmp++; if (iss_ready !== 1'b1) begin n_err++; $display("FAIL lu_iss_ready0: got %b exp 1", iss_ready); end
        tick();
        iss_valid = 1'b0; dec_rd = 5'd7;
        #1;
        n_cmp++; if (hazard_stall !== 1'b1) begin n_err++; $display("FAIL lu_stall_issued: got %b exp 1", hazard_stall); end
        n_cmp++; if (iss_ready !== 1'b0) begin n_err++; $display("FAIL lu_iss_ready1: got %b exp 0", iss_ready); end
        lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 32'h77;
        tick();
        lu_valid = 1'b0;
        n_cmp++; if (ru_wr !== 1'b0) begin n_err++; $display("FAIL lu_no_bypass: got %b exp 0", ru_wr); end
        n_cmp++; if (hazard_stall !== 1'b1) begin n_err++; $display("FAIL lu_stall_queued: got %b exp 1", hazard_stall); end
        tick();
        n_cmp++; if (ru_wr !== 1'b1 || ru_rd !== 5'd7 || ru_data_wr !== 32'h77) begin n_err++; $display("FAIL lu_write: got %b/%0d/%h exp 1/7/77", ru_wr, ru_rd, ru_data_wr); end
        n_cmp++; if (hazard_stall !== 1'b0) begin n_err++; $display("FAIL lu_stall_clear: got %b exp 0", hazard_stall); end
        n_cmp++; if (iss_ready !== 1'b1) begin n_err++; $display("FAIL lu_iss_ready2: got %b exp 1", iss_ready); end
        dec_rd = 5'd0;
        tick();
    endtask

    task automatic test_starve();
        pipe_valid = 1'b1; pipe_rd = 5'd1; pipe_data = 32'h11;
        lu_valid = 1'b1; lu_rd = 5'd9; lu_data = 32'h99;
        for (int i = 1; i <= 12; i++) begin
            tick();
            lu_valid = 1'b0;
            n_cmp++; if (pipe_hold !== (i >= 9)) begin n_err++; $display("FAIL starve_hold[%0d]: got %b exp %b", i, pipe_hold, i >= 9); end
            n_cmp++; if (ru_wr !== 1'b1 || ru_rd !== 5'd1) begin n_err++; $display("FAIL starve_pipe[%0d]: got %b/%0d exp 1/1", i, ru_wr, ru_rd); end
        end
        pipe_valid = 1'b0;
        tick();
        n_cmp++; if (ru_wr !== 1'b1 || ru_rd !== 5'd9 || ru_data_wr !== 32'h99) begin n_err++; $display("FAIL starve_drain: got %b/%0d/%h exp 1/9/99", ru_wr, ru_rd, ru_data_wr); end
        n_cmp++; if (pipe_hold !== 1'b0) begin n_err++; $display("FAIL starve_release: got %b exp 0", pipe_hold); end
        tick();
    endtask

    task automatic test_back_to_back();
        pipe_valid = 1'b1; pipe_rd = 5'd2; pipe_data = 32'h22;
        for (int i = 0; i < 4; i++) begin
            lu_valid = 1'b1; lu_rd = 5'(10 + i); lu_data = 32'h100 + 32'(i);
            #1;
            n_cmp++; if (lu_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready[%0d]: got %b exp 1", i, lu_ready); end
            tick();
        end
        lu_rd = 5'd14; lu_data = 32'h104;
        n_cmp++; if (lu_ready !== 1'b0) begin n_err++; $display("FAIL b2b_full: got %b exp 0", lu_ready); end
        tick();
        pipe_valid = 1'b0;
        n_cmp++; if (lu_ready !== 1'b0) begin n_err++; $display("FAIL b2b_full_hold: got %b exp 0", lu_ready); end
        tick();
        n_cmp++; if (ru_wr !== 1'b1 || ru_rd !== 5'd10 || ru_data_wr !== 32'h100) begin n_err++; $display("FAIL b2b_out0: got %b/%0d/%h exp 1/10/100", ru_wr, ru_rd, ru_data_wr); end
        n_cmp++; if (lu_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_again: got %b exp 1", lu_ready); end
        tick();
        lu_valid = 1'b0;
        for (int i = 1; i < 5; i++) begin
            n_cmp++; if (ru_wr !== 1'b1 || ru_rd !== 5'(10 + i) || ru_data_wr !== 32'h100 + 32'(i)) begin n_err++; $display("FAIL b2b_out%0d: got %b/%0d/%h exp 1/%0d/%h", i, ru_wr, ru_rd, ru_data_wr, 10 + i, 32'h100 + 32'(i)); end
            tick();
        end
        n_cmp++; if (ru_wr !== 1'b0) begin n_err++; $display("FAIL b2b_empty: got %b exp 0", ru_wr); end
    endtask

    task automatic test_waw_rd0();
        iss_valid = 1'b1; iss_rd = 5'd3;
        tick();
        #1;
        n_cmp++; if (iss_ready !== 1'b0) begin n_err++; $display("FAIL waw_block: got %b exp 0", iss_ready); end
        iss_valid = 1'b0;
        pipe_valid = 1'b1; pipe_rd = 5'd0; pipe_data = 32'hDEAD;
        lu_valid = 1'b1; lu_rd = 5'd0; lu_data = 32'hBEEF;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (ru_wr !== 1'b0) begin n_err++; $display("FAIL rd0_wr[%0d]: got %b exp 0", i, ru_wr); end
            n_cmp++; if (lu_ready !== 1'b1) begin n_err++; $display("FAIL rd0_ready[%0d]: got %b exp 1", i, lu_ready); end
        end
        pipe_valid = 1'b0; lu_valid = 1'b0;
        tick();
        n_cmp++; if (ru_wr !== 1'b0) begin n_err++; $display("FAIL rd0_drain: got %b exp 0", ru_wr); end
    endtask

    task automatic test_reset_mid();
        pipe_valid = 1'b1; pipe_rd = 5'd4; pipe_data = 32'h44;
        for (int i = 0; i < 3; i++) begin
            lu_valid = 1'b1; lu_rd = 5'(20 + i); lu_data = 32'(i);
            tick();
        end
        lu_valid = 1'b0;
        dec_rd = 5'd3;
        #2;
        n_cmp++; if (ru_wr !== 1'b1 || hazard_stall !== 1'b1) begin n_err++; $display("FAIL mid_pre: got %b/%b exp 1/1", ru_wr, hazard_stall); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (ru_wr !== 1'b0) begin n_err++; $display("FAIL mid_rst_wr: got %b exp 0", ru_wr); end
        n_cmp++; if (hazard_stall !== 1'b0 || iss_ready !== 1'b1) begin n_err++; $display("FAIL mid_rst_pending: got %b/%b exp 0/1", hazard_stall, iss_ready); end
        pipe_valid = 1'b0; dec_rd = 5'd0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++; if (ru_wr !== 1'b0) begin n_err++; $display("FAIL mid_post_wr[%0d]: got %b exp 0", i, ru_wr); end
            n_cmp++; if (lu_ready !== 1'b1 || pipe_hold !== 1'b0) begin n_err++; $display("FAIL mid_post_flags[%0d]: got %b/%b exp 1/0", i, lu_ready, pipe_hold); end
        end
    endtask

    initial begin
        test_reset();
        test_pipe();
        test_lu();
        test_starve();
        test_back_to_back();
        test_waw_rd0();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
